uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 97 +++++++++
 tb/tb_uart_tx_feeder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter: pops one byte per idle transmitter,
// strobes DATA_VALID for one cycle, then waits for Busy to rise and fall.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [AW:0]           COUNT,
  output logic                  OVERFLOW,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            state;
  logic                  do_write;
  logic                  do_pop;
  logic [AW:0]           count_nxt;

  // FULL/EMPTY are registered, so a write in the cycle of a pop from a full
  // FIFO is still dropped even though a slot frees up at the same edge.
  assign do_write = WR_EN && !FULL;
  assign do_pop   = (state == IDLE) && !EMPTY && !TX_BUSY;

  always_comb begin
    count_nxt = COUNT;
    if (do_write && !do_pop)
      count_nxt = COUNT + ONE_CNT;
    else if (!do_write && do_pop)
      count_nxt = COUNT - ONE_CNT;
  end

  always_ff @(posedge CLK) begin
    if (do_write)
      mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      COUNT         <= '0;
      FULL          <= 1'b0;
      EMPTY         <= 1'b1;
      OVERFLOW      <= 1'b0;
      TX_DATA_VALID <= 1'b0;
      TX_P_DATA     <= '0;
      state         <= IDLE;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + ONE_PTR;
        TX_P_DATA <= mem[rd_ptr];
      end
      COUNT         <= count_nxt;
      FULL          <= (count_nxt == DEPTH_CNT);
      EMPTY         <= (count_nxt == '0);
      OVERFLOW      <= WR_EN && FULL;
      TX_DATA_VALID <= do_pop;

      case (state)
        IDLE: begin
          if (do_pop)
            state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TX_BUSY)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!TX_BUSY)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter Busy model.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       tx_busy;
  logic [7:0] tx_p_data;
  logic       tx_data_valid;

  logic       busy_manual;
  logic       model_en;
  logic       model_busy;
  int         model_cnt;

  logic [7:0] sq[$];
  int         sc[$];
  int         cyc;
  int         last_strobe;
  int         bad_b2b;
  int         bad_busy;
  logic       prev_busy;

  int errors;
  int checks;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .CLK           (clk),
    .RST           (rst),
    .WR_DATA       (wr_data),
    .WR_EN         (wr_en),
    .FULL          (full),
    .EMPTY         (empty),
    .COUNT         (count),
    .OVERFLOW      (overflow),
    .TX_BUSY       (tx_busy),
    .TX_P_DATA     (tx_p_data),
    .TX_DATA_VALID (tx_data_valid)
  );

  assign tx_busy = model_en ? model_busy : busy_manual;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter: Busy rises the cycle after a strobe and stays high 11 cycles.
  initial begin
    model_busy = 1'b0;
    model_cnt  = 0;
  end
  always @(posedge clk) begin
    if (tx_data_valid) begin
      model_busy <= 1'b1;
      model_cnt  <= 10;
    end else if (model_busy) begin
      if (model_cnt == 0)
        model_busy <= 1'b0;
      else
        model_cnt <= model_cnt - 1;
    end
  end

  // Strobe monitor
  initial begin
    cyc         = 0;
    last_strobe = -10;
    bad_b2b     = 0;
    bad_busy    = 0;
    prev_busy   = 1'b0;
  end
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_busy <= tx_busy;
    if (tx_data_valid) begin
      sq.push_back(tx_p_data);
      sc.push_back(cyc);
      if (cyc - last_strobe <= 1)
        bad_b2b <= bad_b2b + 1;
      if (prev_busy)
        bad_busy <= bad_busy + 1;
      last_strobe <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (sq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(sq.size() >= n), 32'd1);
  endtask

  initial begin
    int base;
    int bad;
    int k;
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    busy_manual = 1'b0;
    model_en    = 1'b0;

    // Reset state
    tick(2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_pdata", 32'(tx_p_data), 32'd0);
    rst = 1'b0;
    tick(3);
    chk("no_pop_before_write", 32'(sq.size()), 32'd0);

    // Single byte: strobe exactly two cycles after the write
    do_reset();
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    chk("single_empty_n1", 32'(empty), 32'd0);
    chk("single_count_n1", 32'(count), 32'd1);
    chk("single_valid_n1", 32'(tx_data_valid), 32'd0);
    tick(1);
    chk("single_valid_n2", 32'(tx_data_valid), 32'd1);
    chk("single_pdata_n2", 32'(tx_p_data), 32'hA5);
    chk("single_count_n2", 32'(count), 32'd0);
    chk("single_empty_n2", 32'(empty), 32'd1);
    tick(1);
    chk("single_valid_n3", 32'(tx_data_valid), 32'd0);
    chk("single_pdata_hold", 32'(tx_p_data), 32'hA5);

    // Burst of 5 with transmitter model
    do_reset();
    model_en = 1'b1;
    base = sq.size();
    for (int i = 1; i <= 5; i++)
      write_byte(8'(i));
    wait_strobes("burst_timeout", base + 5, 300);
    tick(20);
    chk("burst_strobes", 32'(sq.size() - base), 32'd5);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (base + i >= sq.size() || sq[base + i] !== 8'(i + 1)) bad++;
    chk("burst_order", 32'(bad), 32'd0);
    chk("burst_count_end", 32'(count), 32'd0);

    // Full / overflow
    model_en    = 1'b0;
    busy_manual = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++)
      write_byte(8'h10 + 8'(i));
    chk("full_after8", 32'(full), 32'd1);
    chk("count_after8", 32'(count), 32'd8);
    chk("no_ovf_after8", 32'(overflow), 32'd0);
    write_byte(8'h18);
    chk("ovf_on9", 32'(overflow), 32'd1);
    chk("count_on9", 32'(count), 32'd8);
    tick(1);
    chk("ovf_pulse_once", 32'(overflow), 32'd0);
    base = sq.size();
    model_en = 1'b1;
    wait_strobes("full_drain_timeout", base + 8, 400);
    tick(20);
    chk("full_drain_strobes", 32'(sq.size() - base), 32'd8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (base + i >= sq.size() || sq[base + i] !== 8'h10 + 8'(i)) bad++;
    chk("full_drain_order", 32'(bad), 32'd0);
    chk("full_drain_empty", 32'(empty), 32'd1);

    // Simultaneous write and pop, FIFO full
    model_en    = 1'b0;
    busy_manual = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++)
      write_byte(8'h20 + 8'(i));
    busy_manual = 1'b0;
    wr_data     = 8'h99;
    wr_en       = 1'b1;
    tick(1);
    wr_en       = 1'b0;
    busy_manual = 1'b1;
    chk("sim_full_ovf", 32'(overflow), 32'd1);
    chk("sim_full_count", 32'(count), 32'd7);
    chk("sim_full_valid", 32'(tx_data_valid), 32'd1);
    chk("sim_full_pdata", 32'(tx_p_data), 32'h20);

    // Simultaneous write and pop, COUNT=3
    do_reset();
    for (int i = 0; i < 3; i++)
      write_byte(8'h30 + 8'(i));
    busy_manual = 1'b0;
    wr_data     = 8'h33;
    wr_en       = 1'b1;
    tick(1);
    wr_en       = 1'b0;
    busy_manual = 1'b1;
    chk("sim3_count", 32'(count), 32'd3);
    chk("sim3_ovf", 32'(overflow), 32'd0);
    chk("sim3_pdata", 32'(tx_p_data), 32'h30);
    tick(1);
    base = sq.size();
    model_en = 1'b1;
    wait_strobes("sim3_timeout", base + 3, 300);
    tick(20);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (base + i >= sq.size() || sq[base + i] !== 8'h31 + 8'(i)) bad++;
    chk("sim3_order", 32'(bad), 32'd0);
    chk("sim3_strobes", 32'(sq.size() - base), 32'd3);

    // Wrap: 20 writes interleaved with transmissions
    do_reset();
    base = sq.size();
    for (int i = 0; i < 20; i++) begin
      k = 0;
      while (full && k < 200) begin
        tick(1);
        k++;
      end
      write_byte(8'h40 + 8'(i));
      tick(3);
    end
    wait_strobes("wrap_timeout", base + 20, 1000);
    tick(20);
    chk("wrap_strobes", 32'(sq.size() - base), 32'd20);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (base + i >= sq.size() || sq[base + i] !== 8'h40 + 8'(i)) bad++;
    chk("wrap_order", 32'(bad), 32'd0);

    // Reset mid-flight in WAIT_DONE with COUNT=4
    model_en    = 1'b0;
    busy_manual = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++)
      write_byte(8'h50 + 8'(i));
    busy_manual = 1'b1;
    tick(2);
    chk("mid_count4", 32'(count), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_valid", 32'(tx_data_valid), 32'd0);
    chk("mid_rst_pdata", 32'(tx_p_data), 32'd0);
    tick(1);
    rst         = 1'b0;
    busy_manual = 1'b0;
    base = sq.size();
    tick(3);
    chk("mid_no_pop", 32'(sq.size() - base), 32'd0);
    write_byte(8'h3C);
    wait_strobes("mid_timeout", base + 1, 50);
    chk("mid_first_byte", 32'((sq.size() > base) ? sq[base] : 8'h00), 32'h3C);
    tick(10);
    chk("mid_strobes", 32'(sq.size() - base), 32'd1);

    chk("no_back_to_back", 32'(bad_b2b), 32'd0);
    chk("strobe_after_busy_low", 32'(bad_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
